// File: rtl/pc_predict_bp_pkg.sv
// rtl/pc_predict_bp_pkg.sv - shared pipeline constants for the fetch-side PC predictor
//
// Purpose: instruction codes seen by fetch/M/W and the 2-bit branch-history
// counter encoding, plus the saturating counter update helpers.
// Ports: none (package).

package pc_predict_bp_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    CNT_STRONG_NT = 2'd0,
    CNT_WEAK_NT   = 2'd1,
    CNT_WEAK_T    = 2'd2,
    CNT_STRONG_T  = 2'd3
  } bht_cnt_e;

  localparam bht_cnt_e CNT_RESET = CNT_WEAK_T;

  // Saturating step toward the resolved direction.
  function automatic bht_cnt_e cnt_update(input bht_cnt_e c, input logic taken);
    bht_cnt_e r;
    r = c;
    if (taken) begin
      if (c != CNT_STRONG_T) r = bht_cnt_e'(c + 2'd1);
    end else begin
      if (c != CNT_STRONG_NT) r = bht_cnt_e'(c - 2'd1);
    end
    return r;
  endfunction

  function automatic logic cnt_taken(input bht_cnt_e c);
    return (c == CNT_WEAK_T) || (c == CNT_STRONG_T);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack
//
// Purpose: push/pop stack of return addresses. When full, a push overwrites
// the oldest entry and sets a sticky overflow flag; a pop on empty is ignored.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i          push push_data_i this cycle (takes priority over pop_i)
//   pop_i           pop the top entry this cycle
//   push_data_i     address to push
//   top_o           newest live entry (undefined content when empty)
//   empty_o         no live entries
//   overflow_o      sticky: a push overwrote a live entry

module ras_stack #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              overflow_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;   // next free slot; top lives at ptr_q-1
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  top_idx;

  assign top_idx    = ptr_q - 1'b1;
  assign top_o      = mem_q[top_idx];
  assign empty_o    = (cnt_q == '0);
  assign overflow_o = ovf_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push_i) begin
      // The pointer wraps naturally, so a full push lands on the oldest slot.
      ptr_d = ptr_q + 1'b1;
      if (cnt_q == CNT_FULL) ovf_d = 1'b1;
      else                   cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage needs no reset: nothing is visible until counted live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_predict_bp.sv
// rtl/pc_predict_bp.sv - fetch PC selection with bimodal branch predictor and RAS
//
// Purpose: selects the fetch PC (with M-stage jXX and W-stage ret correction),
// predicts the next fetch address using a 2-bit counter BHT for jXX, the call
// target for call and a return-address stack for ret.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   F_stall                      hold fetch register, suppress RAS activity
//   f_icode/f_valC/f_valP        fetched instruction fields
//   M_valid/M_icode/M_Cnd/M_pc   M-stage branch resolution
//   M_pred_taken/M_valA/M_valC   M-stage prediction and both outcomes
//   W_icode/W_valM/W_predPC      W-stage ret true vs predicted address
//   f_PC                         address fetched this cycle
//   f_predPC                     next-fetch prediction (fetch register D)
//   f_pred_taken                 jXX predicted taken
//   redirect                     f_PC taken from an M/W correction
//   ras_overflow                 sticky RAS overwrite flag

module pc_predict_bp
  import pc_predict_bp_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int BHT_DEPTH = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              F_stall,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic              M_valid,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [ADDR_W-1:0] M_pc,
  input  logic              M_pred_taken,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic [ADDR_W-1:0] M_valC,
  input  logic [3:0]        W_icode,
  input  logic [ADDR_W-1:0] W_valM,
  input  logic [ADDR_W-1:0] W_predPC,
  output logic [ADDR_W-1:0] f_PC,
  output logic [ADDR_W-1:0] f_predPC,
  output logic              f_pred_taken,
  output logic              redirect,
  output logic              ras_overflow
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [ADDR_W-1:0] F_predPC_q;
  bht_cnt_e          bht_q [BHT_DEPTH];

  logic              m_jxx, m_fix_nt, m_fix_t, w_fix;
  logic [IDX_W-1:0]  lk_idx, upd_idx;
  bht_cnt_e          lk_cnt, upd_cnt_d;
  logic              ras_push, ras_pop, ras_empty;
  logic [ADDR_W-1:0] ras_top;
  logic              unused_pc_hi;

  assign unused_pc_hi = ^M_pc[ADDR_W-1:IDX_W];

  // ---------------- fetch PC selection ----------------
  assign m_jxx    = M_valid && (M_icode == IJXX);
  assign m_fix_nt = m_jxx &&  M_pred_taken && !M_Cnd;
  assign m_fix_t  = m_jxx && !M_pred_taken &&  M_Cnd;
  assign w_fix    = (W_icode == IRET) && (W_valM != W_predPC);

  always_comb begin
    f_PC     = F_predPC_q;
    redirect = 1'b0;
    if (m_fix_nt) begin
      f_PC     = M_valA;
      redirect = 1'b1;
    end else if (m_fix_t) begin
      f_PC     = M_valC;
      redirect = 1'b1;
    end else if (w_fix) begin
      f_PC     = W_valM;
      redirect = 1'b1;
    end
  end

  // ---------------- next-PC prediction ----------------
  // Lookup reads the registered counter, so a same-cycle update to the same
  // index is not visible until the following cycle.
  assign lk_idx = f_PC[IDX_W-1:0];
  assign lk_cnt = bht_q[lk_idx];

  always_comb begin
    f_predPC     = f_valP;
    f_pred_taken = 1'b0;
    case (f_icode)
      IJXX: begin
        if (cnt_taken(lk_cnt)) begin
          f_predPC     = f_valC;
          f_pred_taken = 1'b1;
        end
      end
      ICALL:   f_predPC = f_valC;
      IRET:    if (!ras_empty) f_predPC = ras_top;
      default: f_predPC = f_valP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        F_predPC_q <= '0;
    else if (!F_stall) F_predPC_q <= f_predPC;
  end

  // ---------------- branch history table ----------------
  assign upd_idx   = M_pc[IDX_W-1:0];
  assign upd_cnt_d = cnt_update(bht_q[upd_idx], M_Cnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_RESET;
    end else if (m_jxx) begin
      bht_q[upd_idx] <= upd_cnt_d;
    end
  end

  // ---------------- return address stack ----------------
  // Wrong-path pushes/pops are not undone; a bad ret prediction is caught
  // later by the W-stage compare.
  assign ras_push = !F_stall && !redirect && (f_icode == ICALL);
  assign ras_pop  = !F_stall && !redirect && (f_icode == IRET) && !ras_empty;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (f_valP),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .overflow_o  (ras_overflow)
  );

endmodule

// File: tb/tb_pc_predict_bp.sv
// tb/tb_pc_predict_bp.sv - directed self-checking bench for pc_predict_bp

module tb_pc_predict_bp;

  localparam int ADDR_W    = 64;
  localparam int BHT_DEPTH = 16;
  localparam int RAS_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              F_stall;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC, f_valP;
  logic              M_valid;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [ADDR_W-1:0] M_pc;
  logic              M_pred_taken;
  logic [ADDR_W-1:0] M_valA, M_valC;
  logic [3:0]        W_icode;
  logic [ADDR_W-1:0] W_valM, W_predPC;
  logic [ADDR_W-1:0] f_PC, f_predPC;
  logic              f_pred_taken, redirect, ras_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  pc_predict_bp #(
    .ADDR_W    (ADDR_W),
    .BHT_DEPTH (BHT_DEPTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .F_stall      (F_stall),
    .f_icode      (f_icode),
    .f_valC       (f_valC),
    .f_valP       (f_valP),
    .M_valid      (M_valid),
    .M_icode      (M_icode),
    .M_Cnd        (M_Cnd),
    .M_pc         (M_pc),
    .M_pred_taken (M_pred_taken),
    .M_valA       (M_valA),
    .M_valC       (M_valC),
    .W_icode      (W_icode),
    .W_valM       (W_valM),
    .W_predPC     (W_predPC),
    .f_PC         (f_PC),
    .f_predPC     (f_predPC),
    .f_pred_taken (f_pred_taken),
    .redirect     (redirect),
    .ras_overflow (ras_overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_jxx(input logic [63:0] pc, input logic cnd, input logic pred);
    M_valid = 1'b1; M_icode = 4'h7; M_pc = pc; M_Cnd = cnd; M_pred_taken = pred;
  endtask

  initial begin
    rst_n = 1'b0; F_stall = 1'b0;
    f_icode = 4'h1; f_valC = '0; f_valP = '0;
    M_valid = 1'b0; M_icode = 4'h1; M_Cnd = 1'b0; M_pc = '0; M_pred_taken = 1'b0;
    M_valA = '0; M_valC = '0;
    W_icode = 4'h1; W_valM = '0; W_predPC = '0;

    // reset state
    #3;
    check("rst_f_PC", f_PC, 64'h0);
    check("rst_redirect", redirect, 0);
    check("rst_ovf", ras_overflow, 0);
    check("rst_predPC", f_predPC, 64'h0);
    check("rst_taken", f_pred_taken, 0);
    step(); step();
    rst_n = 1'b1;

    // steer fetch to 0x10
    f_valP = 64'h10;
    step();
    check("fpc_0x10", f_PC, 64'h10);

    // jXX at 0x10 weakly taken after reset; same-cycle update sees old value
    F_stall = 1'b1;
    f_icode = 4'h7; f_valC = 64'h40; f_valP = 64'h19;
    m_jxx(64'h10, 1'b0, 1'b0);
    #1;
    check("jxx_pred", f_predPC, 64'h40);
    check("jxx_taken", f_pred_taken, 1);
    check("jxx_noredir", redirect, 0);
    step();
    check("bht1_pred", f_predPC, 64'h19);
    check("bht1_taken", f_pred_taken, 0);
    check("stall_hold", f_PC, 64'h10);
    step();
    check("bht0_pred", f_predPC, 64'h19);
    step();                       // third decrement saturates at 0
    m_jxx(64'h10, 1'b1, 1'b1);
    step(); step();               // 0 -> 1 -> 2
    check("sat_low", f_predPC, 64'h40);
    step(); step();               // 3, stays 3
    m_jxx(64'h10, 1'b0, 1'b0);
    step(); step();               // 3 -> 2 -> 1
    check("sat_high", f_predPC, 64'h19);

    // corrections (combinational only)
    M_pred_taken = 1'b1; M_Cnd = 1'b0; M_valA = 64'h19; M_valC = 64'h40;
    W_icode = 4'h9; W_valM = 64'h77; W_predPC = 64'h88;
    #1;
    check("fix_nt_pc", f_PC, 64'h19);
    check("fix_nt_redir", redirect, 1);
    M_valid = 1'b0;
    #1;
    check("fix_ret_pc", f_PC, 64'h77);
    check("fix_ret_redir", redirect, 1);
    W_valM = 64'h88;
    #1;
    check("ret_ok_redir", redirect, 0);
    check("ret_ok_pc", f_PC, 64'h10);
    M_valid = 1'b1; M_pred_taken = 1'b0; M_Cnd = 1'b1;
    #1;
    check("fix_t_pc", f_PC, 64'h40);
    check("fix_t_redir", redirect, 1);
    M_valid = 1'b0; W_icode = 4'h1;

    // call / ret
    F_stall = 1'b0; f_icode = 4'h1; f_valP = 64'h20;
    step();
    check("fpc_0x20", f_PC, 64'h20);
    f_icode = 4'h8; f_valC = 64'h100; f_valP = 64'h29;
    #1;
    check("call_pred", f_predPC, 64'h100);
    step();
    f_icode = 4'h9; f_valP = 64'h101;
    #1;
    check("ret_pred", f_predPC, 64'h29);
    step();
    f_icode = 4'h1; W_icode = 4'h9; W_valM = 64'h29; W_predPC = 64'h29;
    #1;
    check("ret_match_redir", redirect, 0);
    check("ret_match_pc", f_PC, 64'h29);
    W_icode = 4'h1;

    // stalled call must not push
    F_stall = 1'b1; f_icode = 4'h8; f_valC = 64'h130; f_valP = 64'h30;
    step();
    F_stall = 1'b0; f_icode = 4'h9; f_valP = 64'h66;
    #1;
    check("stall_nopush", f_predPC, 64'h66);
    step();                       // pop on empty: no effect

    // call during a redirect must not push
    f_icode = 4'h8; f_valC = 64'h170; f_valP = 64'h70;
    m_jxx(64'h3, 1'b0, 1'b1); M_valA = 64'h200;
    step();
    M_valid = 1'b0; f_icode = 4'h9; f_valP = 64'h99;
    #1;
    check("redir_nopush", f_predPC, 64'h99);

    // overflow: RAS_DEPTH+1 calls then RAS_DEPTH+1 rets
    for (int i = 0; i <= RAS_DEPTH; i++) begin
      f_icode = 4'h8; f_valC = 64'h800; f_valP = 64'h1000 + 64'(i);
      step();
      if (i == RAS_DEPTH - 1) check("ovf_before", ras_overflow, 0);
    end
    check("ovf_after", ras_overflow, 1);
    for (int i = 0; i <= RAS_DEPTH; i++) begin
      f_icode = 4'h9; f_valP = 64'h2000 + 64'(i);
      #1;
      if (i < RAS_DEPTH) check("ovf_ret", f_predPC, 64'h1000 + 64'(RAS_DEPTH - i));
      else               check("ovf_ret_last", f_predPC, 64'h2000 + 64'(RAS_DEPTH));
      step();
    end

    // asynchronous reset mid-sequence
    f_icode = 4'h1; f_valP = 64'h0;
    m_jxx(64'h0, 1'b0, 1'b0);
    step(); step();               // BHT[0] -> 0
    M_valid = 1'b0;
    f_icode = 4'h8; f_valC = 64'h600; f_valP = 64'h500;
    step();
    f_icode = 4'h7; f_valC = 64'h444; f_valP = 64'h9;
    #1;
    check("pre_rst_pc", f_PC, 64'h600);
    check("pre_rst_pred", f_predPC, 64'h9);
    check("pre_rst_ovf", ras_overflow, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", f_PC, 64'h0);
    check("arst_pred", f_predPC, 64'h444);
    check("arst_taken", f_pred_taken, 1);
    check("arst_ovf", ras_overflow, 0);
    f_icode = 4'h9; f_valP = 64'h333;
    #1;
    check("arst_ras_empty", f_predPC, 64'h333);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_predict_bp.md
PC_PREDICT_BP -- requirements
Module: pc_predict_bp

Interface
REQ-001 Parameter ADDR_W, default 64, PC and data width in bits.
REQ-002 Parameter BHT_DEPTH, default 16, branch-history entries; power of two, >=2.
REQ-003 Parameter RAS_DEPTH, default 8, return-address-stack entries; power of two, >=2.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- F_stall  in  1  hold fetch register; suppress RAS push/pop.
- f_icode  in  4  icode of instruction fetched at f_PC.
- f_valC  in  ADDR_W  fetched constant (jXX/call target).
- f_valP  in  ADDR_W  fetched fall-through address.
- M_valid  in  1  M stage holds a real instruction, not a bubble.
- M_icode  in  4  M-stage icode.
- M_Cnd  in  1  M-stage resolved condition.
- M_pc  in  ADDR_W  M-stage instruction address.
- M_pred_taken  in  1  prediction carried down the pipe with M instruction.
- M_valA  in  ADDR_W  M-stage fall-through address.
- M_valC  in  ADDR_W  M-stage jump target.
- W_icode  in  4  W-stage icode.
- W_valM  in  ADDR_W  true return address popped from memory.
- W_predPC  in  ADDR_W  address predicted for the instruction after W's ret.
- f_PC  out  ADDR_W  address to fetch this cycle.
- f_predPC  out  ADDR_W  prediction for next fetch (D input of fetch register).
- f_pred_taken  out  1  jXX predicted taken; travels down pipe.
- redirect  out  1  f_PC sourced from M or W correction this cycle.
- ras_overflow  out  1  sticky: a push overwrote a live entry.

Function
REQ-005 f_PC SHALL be combinational, priority: (a) M_valid, M_icode==7, M_pred_taken && !M_Cnd -> M_valA; (b) M_valid, M_icode==7, !M_pred_taken && M_Cnd -> M_valC; (c) W_icode==9 && W_valM!=W_predPC -> W_valM; (d) else fetch register F_predPC.
REQ-006 redirect SHALL be 1 exactly when case (a), (b) or (c) selects f_PC.
REQ-007 f_predPC SHALL be: icode 2,3,4,5,6,10,11 -> f_valP; 7 -> f_valC if BHT[f_PC] counter>=2 else f_valP; 8 -> f_valC; 9 -> RAS top if RAS non-empty else f_valP; any other icode -> f_valP.
REQ-008 f_pred_taken SHALL be 1 only for f_icode==7 with counter>=2.
REQ-009 F_predPC register SHALL load f_predPC each rising edge unless F_stall; latency from f_PC to next fetch = 1 cycle.
REQ-010 BHT index SHALL be PC[log2(BHT_DEPTH)-1:0]; entries are 2-bit saturating counters.
REQ-011 When M_valid && M_icode==7, BHT[M_pc] SHALL increment (sat 3) if M_Cnd else decrement (sat 0) at the clock edge, regardless of F_stall.
REQ-012 Same-cycle lookup and update of one index: lookup SHALL see the pre-update value.
REQ-013 When !F_stall, f_icode==8 SHALL push f_valP; f_icode==9 with non-empty RAS SHALL pop; pushes/pops suppressed when F_stall or redirect.
REQ-014 RAS SHALL be circular; push when full overwrites oldest entry, count stays RAS_DEPTH, sets ras_overflow.
REQ-015 Pop on empty RAS SHALL leave count 0 and change nothing.
REQ-016 RAS SHALL not be repaired on redirect; wrong-path effects appear only as later ret mismatch, corrected by REQ-005(c).

Reset
REQ-017 While rst_n low: F_predPC=0, all BHT counters=2 (weakly taken), RAS count=0, pointer=0, ras_overflow=0; f_PC=0 when no correction is active.
REQ-018 Reset assertion mid-operation SHALL take effect immediately, discarding any in-progress update.

Structure
REQ-019 Icode constants (IJXX=7, ICALL=8, IRET=9, etc.) and counter encodings SHALL live in the shared pipeline package.
REQ-020 RAS SHALL be a sub-module ras_stack (params ADDR_W, RAS_DEPTH; push, pop, top, empty, overflow).

Verification
REQ-021 Reset, jXX at 0x10 valC=0x40 valP=0x19 -> f_predPC=0x40, f_pred_taken=1.
REQ-022 Two M updates of index 0x10 with Cnd=0 -> next jXX at 0x10 predicts 0x19; third keeps counter at 0.
REQ-023 M jXX pred_taken=1, Cnd=0, valA=0x19, W ret mismatch same cycle -> f_PC=0x19, redirect=1.
REQ-024 call at 0x20 (valP=0x29), later ret -> f_predPC=0x29; W_valM=0x29=W_predPC -> redirect=0.
REQ-025 RAS_DEPTH+1 calls, then RAS_DEPTH+1 rets -> ras_overflow=1, first RAS_DEPTH rets predict newest-first, last ret predicts its valP.
REQ-026 rst_n low mid-sequence -> all state to REQ-017 values asynchronously.
